// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage feeding the 8-bit ALU.
// Holds the general register file and flag register, reads and bypasses
// source operands, tracks outstanding destinations in a pending
// scoreboard, and hands a registered {op, ina, inb, rd} bundle to the ALU
// over valid/ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        decode handshake (in_ready is combinational)
//   in_op, in_rs1, in_rs2,     instruction fields from decode
//   in_rd, in_imm, in_use_imm
//   out_valid / out_ready      ALU handshake
//   out_op, out_ina, out_inb,  registered bundle toward the ALU
//   out_rd
//   wb_en, wb_rd, wb_data,     ALU writeback (data and flags)
//   wb_flags
//   flags                      flag register {cr, ov, ng, zr}
//   pending                    scoreboard, one bit per register
module alu_operand_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned RW     = $clog2(NREGS),
    localparam int unsigned OP_W   = 4,
    localparam int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [RW-1:0]     in_rs1,
    input  logic [RW-1:0]     in_rs2,
    input  logic [RW-1:0]     in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_ina,
    output logic [DATA_W-1:0] out_inb,
    output logic [RW-1:0]     out_rd,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [FLAG_W-1:0] wb_flags,
    output logic [FLAG_W-1:0] flags,
    output logic [NREGS-1:0]  pending
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  wb_mask;
    logic [NREGS-1:0]  acc_mask;
    logic [NREGS-1:0]  pend_eff;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              hazard;
    logic              accept;

    // Hazard check and handshake; a register being written back this
    // cycle is bypassed, so it no longer counts as pending.
    always_comb begin
        wb_mask = '0;
        if (wb_en) begin
            wb_mask[wb_rd] = 1'b1;
        end
        pend_eff = pending & ~wb_mask;
        hazard   = pend_eff[in_rs1]
                 | (~in_use_imm & pend_eff[in_rs2])
                 | pend_eff[in_rd];
        in_ready = (~out_valid | out_ready) & ~hazard;
        accept   = in_valid & in_ready;
        acc_mask = '0;
        if (accept && (in_rd != '0)) begin
            acc_mask[in_rd] = 1'b1;
        end
    end

    // Operand read with r0 hardwired to zero and writeback bypass.
    always_comb begin
        opa = '0;
        opb = in_imm;
        if (in_rs1 != '0) begin
            opa = (wb_en && (wb_rd == in_rs1)) ? wb_data : regs[in_rs1];
        end
        if (!in_use_imm) begin
            opb = '0;
            if (in_rs2 != '0) begin
                opb = (wb_en && (wb_rd == in_rs2)) ? wb_data : regs[in_rs2];
            end
        end
    end

    // Register file; entry 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (wb_en && (wb_rd == RW'(i))) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    // Scoreboard and flags; a same-edge set overrides the writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            flags   <= '0;
        end else begin
            pending <= (pending & ~wb_mask) | acc_mask;
            if (wb_en) begin
                flags <= wb_flags;
            end
        end
    end

    // Output bundle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_ina   <= '0;
            out_inb   <= '0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_ina   <= opa;
            out_inb   <= opb;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rs1, in_rs2, in_rd;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_op;
    logic [7:0] out_ina, out_inb;
    logic [2:0] out_rd;
    logic       wb_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] wb_flags;
    logic [3:0] flags;
    logic [7:0] pending;

    int n_chk  = 0;
    int n_pass = 0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_ina(out_ina), .out_inb(out_inb), .out_rd(out_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
        .flags(flags), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic [7:0] imm, input logic use_imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = use_imm;
    endtask

    task automatic wb(input logic en, input logic [2:0] rd, input logic [7:0] data,
                      input logic [3:0] fl);
        wb_en    = en;
        wb_rd    = rd;
        wb_data  = data;
        wb_flags = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b1;
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pending",   32'(pending),   32'h00);
        chk("rst_flags",     32'(flags),     32'h0);
        chk("rst_out_ina",   32'(out_ina),   32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // r0 read
        issue(4'b0010, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("r0_valid",   32'(out_valid), 32'd1);
        chk("r0_op",      32'(out_op),    32'h2);
        chk("r0_ina",     32'(out_ina),   32'h00);
        chk("r0_inb",     32'(out_inb),   32'h00);
        chk("r0_pending", 32'(pending),   32'h00);
        chk("r0_flags",   32'(flags),     32'h0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // write r3 then read it with an immediate
        wb(1'b1, 3'd3, 8'h5A, 4'b0001);
        tick();
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        issue(4'h7, 3'd3, 3'd0, 3'd4, 8'h0F, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("wr_ina",     32'(out_ina), 32'h5A);
        chk("wr_inb",     32'(out_inb), 32'h0F);
        chk("wr_rd",      32'(out_rd),  32'd4);
        chk("wr_flags",   32'(flags),   32'b0001);
        chk("wr_pending", 32'(pending), 32'h10);
        wb(1'b1, 3'd4, 8'h11, 4'h0);
        tick();
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        chk("wr_clr_pending", 32'(pending), 32'h00);

        // RAW stall then bypass
        issue(4'h1, 3'd0, 3'd0, 3'd2, 8'h00, 1'b0);
        tick();
        chk("raw_pending", 32'(pending), 32'h04);
        issue(4'h3, 3'd2, 3'd0, 3'd6, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("raw_stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        wb(1'b1, 3'd2, 8'h80, 4'b0010);
        #3;
        chk("raw_bypass_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        chk("raw_valid",   32'(out_valid), 32'd1);
        chk("raw_ina",     32'(out_ina),   32'h80);
        chk("raw_rd",      32'(out_rd),    32'd6);
        chk("raw_pending", 32'(pending),   32'h40);
        chk("raw_flags",   32'(flags),     32'b0010);
        wb(1'b1, 3'd6, 8'h33, 4'h0);
        tick();
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        chk("raw_clr_pending", 32'(pending), 32'h00);

        // backpressure
        issue(4'h9, 3'd2, 3'd3, 3'd0, 8'h00, 1'b0);
        tick();
        chk("bp_ina", 32'(out_ina), 32'h80);
        chk("bp_inb", 32'(out_inb), 32'h5A);
        out_ready = 1'b0;
        issue(4'hF, 3'd3, 3'd0, 3'd0, 8'hAA, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_hold", {out_valid, 3'd0, out_op, out_ina, out_inb, 5'd0, out_rd},
                {1'b1, 3'd0, 4'h9, 8'h80, 8'h5A, 5'd0, 3'd0});
        end
        out_ready = 1'b1;
        #3;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_op",  32'(out_op),  32'hF);
        chk("bp_next_ina", 32'(out_ina), 32'h5A);
        chk("bp_next_inb", 32'(out_inb), 32'hAA);

        // same-edge accept and writeback to r5
        issue(4'h4, 3'd0, 3'd0, 3'd5, 8'h00, 1'b1);
        wb(1'b1, 3'd5, 8'h44, 4'h0);
        tick();
        in_valid = 1'b0;
        chk("conf_pending", 32'(pending), 32'h20);
        wb(1'b1, 3'd5, 8'h55, 4'h0);
        tick();
        chk("conf_clr", 32'(pending), 32'h00);
        // write r0 while reading it; also read r5
        wb(1'b1, 3'd0, 8'hFF, 4'b1000);
        issue(4'h5, 3'd0, 3'd5, 3'd0, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        chk("r0_wr_flags", 32'(flags),   32'b1000);
        chk("r0_wr_ina",   32'(out_ina), 32'h00);
        chk("r5_inb",      32'(out_inb), 32'h55);
        issue(4'h6, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("r0_still_zero", 32'(out_ina), 32'h00);

        // async reset mid-stream
        issue(4'h1, 3'd0, 3'd0, 3'd2, 8'h00, 1'b1);
        tick();
        issue(4'h1, 3'd0, 3'd0, 3'd3, 8'h00, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_pending", 32'(pending),   32'h0C);
        chk("pre_rst_valid",   32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(out_valid), 32'd0);
        chk("arst_pending", 32'(pending),   32'h00);
        chk("arst_flags",   32'(flags),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb(1'b1, 3'd2, 8'h21, 4'h0);
        tick();
        wb(1'b0, 3'd0, 8'h00, 4'h0);
        chk("post_rst_pending", 32'(pending), 32'h00);
        issue(4'h2, 3'd2, 3'd3, 3'd0, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("post_rst_ina", 32'(out_ina), 32'h21);
        chk("post_rst_inb", 32'(out_inb), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage that sits directly upstream of the 8-bit ALU. It holds the 8×8 general register file and a 4-bit flag register, reads and bypasses source operands, and presents a registered {op, ina, inb, rd} bundle to the ALU via valid/ready. A per-register pending scoreboard stalls issue until the ALU result for a destination has been written back, and writeback also updates the flags.

## Interface
Parameters:
- `DATA_W`, 8: datapath and register width.
- `NREGS`, 8: register count; `in_rs1`, `in_rs2`, `in_rd` and `wb_rd` are log2(NREGS) bits wide.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: decode presents an instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `in_op` input 4: ALU operation code, passed through unchanged.
- `in_rs1` input 3: source register for `ina`.
- `in_rs2` input 3: source register for `inb`.
- `in_rd` input 3: destination register.
- `in_imm` input 8: immediate value.
- `in_use_imm` input 1: 1 means `inb` = `in_imm`; `in_rs2` is then ignored.
- `out_valid` output 1: bundle valid toward the ALU.
- `out_ready` input 1: ALU/execute consumes the bundle.
- `out_op` output 4; `out_ina` output 8; `out_inb` output 8; `out_rd` output 3: registered bundle.
- `wb_en` input 1: writeback strobe.
- `wb_rd` input 3: writeback destination.
- `wb_data` input 8: ALU result.
- `wb_flags` input 4: {cr, ov, ng, zr} from the ALU.
- `flags` output 4: flag register {cr, ov, ng, zr}.
- `pending` output 8: scoreboard, one bit per register (debug and verification).

## Operation
- Register file:
  - r0 always reads 0. Writes to r0 are discarded.
  - r1–r7 are written on a rising edge when `wb_en` is high.
- Bypass: a read of rs with `wb_en && wb_rd == rs && rs != 0` returns `wb_data` in the same cycle. A register hit by bypass is treated as not pending for the hazard check.
- Hazard (each term uses effective pending, i.e. after bypass):
  - pending[rs1];
  - pending[rs2] when `in_use_imm` = 0;
  - pending[rd] (WAW).
  - rs = 0 and rd = 0 never cause a hazard.
- `in_ready` = (!out_valid || out_ready) && !hazard. It is combinational and depends on `in_*` fields.
- Accept occurs on `in_valid && in_ready`. At the clock edge:
  - `out_*` ← fetched/bypassed operands, `in_op`, `in_rd`;
  - `out_valid` ← 1;
  - pending[in_rd] ← 1 if `in_rd` != 0.
- Consume without accept: on `out_valid && out_ready && !accept`, `out_valid` ← 0 and `out_*` hold their last values.
- Writeback: pending[wb_rd] ← 0 and `flags` ← `wb_flags`. `flags` update even when `wb_rd` = 0.
- Simultaneous accept and writeback to the same register: the pending set wins, so the bit ends at 1.
- Writeback to a register that is not pending: the data is written and the bit stays 0. This is not an error.
- `in_op` is not decoded. Every code, including undefined ones, passes through.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all registers = 0, `pending` = 0, `flags` = 0;
  - `out_valid` = 0, `out_op`/`out_ina`/`out_inb`/`out_rd` = 0;
  - `in_ready` = 1 after reset.
- Latency: accept at edge N gives `out_valid` high after edge N. Throughput is 1 per cycle when there is no hazard and `out_ready` = 1.
- `out_*` are stable while `out_valid && !out_ready`.
- A dependent instruction (rs = earlier rd) stalls until the cycle its writeback is presented. It issues in that cycle with `wb_data` bypassed.
- Reset mid-operation: the in-flight bundle and scoreboard are discarded. Any writeback arriving after reset is applied as a normal write.

## Test plan
- Reset, then in r0 read: `in_rs1`=0, `in_rs2`=0, op=0010, `out_ready`=1 → next cycle `out_valid`=1, `out_ina`=`out_inb`=0, `pending`=00000000, `flags`=0000.
- Write then read: wb r3=0x5A with flags 0001, then issue rs1=3, imm=0x0F, use_imm=1 → `out_ina`=0x5A, `out_inb`=0x0F, `out_rd` as issued, `flags`=0001.
- RAW stall plus bypass: issue rd=2. Next, offer rs1=2 → `in_ready`=0 for 3 cycles. On the cycle wb_rd=2, wb_data=0x80, wb_flags=0010 → `in_ready`=1 and `out_ina`=0x80.
- Backpressure: hold `out_ready`=0 with `out_valid`=1 → `in_ready`=0 and `out_*` unchanged for 4 cycles. Raise `out_ready` → the next bundle is accepted the same cycle.
- Same-edge conflict: accept rd=5 while wb_rd=5 → `pending`[5]=1 after the edge. A second wb_rd=5 clears it. A write to r0 of 0xFF → r0 still reads 0.
- Async reset pulse mid-stream with `out_valid`=1 and `pending`=0x0C → `out_valid`, `pending` and `flags` go to 0 immediately, without waiting for a clock edge.
